player_motion_ctrl: RTL and testbench
=====================================

Name: player_motion_ctrl

Overview:
Per-frame player kinematics for the play screen, successor to the single-key player mover. Decodes up to NUM_KEYS simultaneous keycodes and applies clamped horizontal motion. Runs a ground/rise/fall jump state machine with gravity. Feeds sprite rendering and collision with a centre position, size, facing and air status, and freezes outside the play state.

Parameters:
COORD_W, 10, width of position outputs (unsigned)
NUM_KEYS, 6, keycode lanes (USB boot report)
X_MIN, 0, leftmost screen column
X_MAX, 639, rightmost screen column
Y_MIN, 0, topmost screen row
Y_FLOOR, 400, centre Y when standing
X_START, 320, centre X after reset
SIZE, 4, half-extent of player box
X_STEP, 2, horizontal pixels per frame
JUMP_V, 12, initial upward speed (pixels/frame)
GRAVITY, 1, speed gain per frame
MAX_FALL, 8, terminal downward speed

Ports:
frame_clk  in  1  frame clock (vertical sync); the only clock
Reset_n  in  1  synchronous, active-low reset
keycodes  in  8*NUM_KEYS  flattened keycode lanes; lane 0 in bits [7:0]
gameState  in  2  global game state
PlayerX  out  COORD_W  centre X
PlayerY  out  COORD_W  centre Y
PlayerS  out  COORD_W  half-size (constant SIZE)
facing  out  1  1 = right, 0 = left
airborne  out  1  high in RISE or FALL
crouch  out  1  grounded and S held

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-low. All state updates once per posedge frame_clk.
- Reset_n low at an edge, including mid-jump or while paused: X=X_START, Y=Y_FLOOR, vy=0, state GROUND, facing=1, crouch=0, airborne=0.
- Keys: any lane equal to 8'd4 (A) means left, 8'd7 (D) right, 8'd26 (W) jump, 8'd22 (S) crouch. 8'd0 lanes are ignored.
- Left and right together give no horizontal motion.
- Jump fires on the rising edge only: W present now and absent on the previous play frame.
- Freeze: if gameState != GS_PLAY, all registers hold, including the W-previous register. Key input is ignored.
- Horizontal motion:
  - vx = -X_STEP (left), +X_STEP (right), else 0. vx is forced to 0 while crouch.
  - X_next = clamp(X+vx, X_MIN+SIZE, X_MAX-SIZE). Clamp, no bounce.
  - Arithmetic uses a COORD_W+2 signed intermediate, so no wrap occurs.
  - facing updates only on a nonzero vx.
- Vertical FSM, vy signed 8-bit:
  - GROUND: jump edge → RISE, and Y_next = Y - JUMP_V with vy = -JUMP_V+GRAVITY applied the same edge. Otherwise Y holds.
  - RISE: Y_next = Y+vy, vy_next = vy+GRAVITY. vy_next >= 0 → FALL.
  - RISE ceiling: if Y+vy <= Y_MIN+SIZE, then Y = Y_MIN+SIZE, vy=0, → FALL.
  - FALL: Y_next = Y+vy, vy_next = min(vy+GRAVITY, MAX_FALL). If Y+vy >= Y_FLOOR, then Y = Y_FLOOR, vy=0, → GROUND.
- Motion timing: position updates always use the freshly computed velocity, never a stale registered one. Key-to-position latency is 1 frame.
- Outputs are registered. crouch = (state==GROUND)&&S. airborne = state!=GROUND.

Optional Feature:
DOUBLE_JUMP_EN
- Defined: one extra jump edge is accepted in RISE or FALL. vy reloads to -JUMP_V and the state goes to RISE. The 1-bit used flag clears on landing or reset.
- Undefined: jump edges while airborne are ignored and no flag exists.

Decomposition:
- Package contra_pkg:
  - gameState constants (GS_PLAY = 2'd1)
  - keycode constants KEY_W, KEY_A, KEY_S, KEY_D
  - vstate_t enum {GROUND, RISE, FALL}
- Sub-module player_key_decode, combinational:
  - inputs: keycodes plus the registered W-previous bit
  - outputs: left, right, jump_edge, crouch_req
  - scans NUM_KEYS lanes with a generate loop

Test Plan:
- Reset, then gameState=GS_PLAY, no keys, 5 frames → PlayerX=320, PlayerY=400, airborne=0, facing=1.
- Hold A (lane 3) → X steps 318, 316, …; reaches 4 after 158 frames and stays 4; facing=0.
- Lanes {A, D} both set → X unchanged for 10 frames; facing unchanged.
- W pulse one frame:
  - after 12 frames Y=322 and state FALL
  - lands at Y=400 exactly, airborne=0
  - W held throughout gives no second jump until released
- Mid-rise gameState=2'd0 for 20 frames → Y and vy frozen. Back to GS_PLAY → trajectory resumes identically.
- Reset_n low at frame 5 of a jump → next edge X=320, Y=400, GROUND.
- With DOUBLE_JUMP_EN: a second W edge at peak restarts rise (Y decreases by 12). A third edge is ignored.

Source files
------------

// File: rtl/contra_pkg.sv
// contra_pkg: shared game-state, keycode and vertical-state definitions for the player logic.
package contra_pkg;

    localparam logic [1:0] GS_PLAY = 2'd1;

    localparam logic [7:0] KEY_A = 8'd4;
    localparam logic [7:0] KEY_D = 8'd7;
    localparam logic [7:0] KEY_S = 8'd22;
    localparam logic [7:0] KEY_W = 8'd26;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } vstate_t;

endpackage

// File: rtl/player_key_decode.sv
// player_key_decode: scans all keycode lanes for A/D/W/S and forms the W rising edge.
module player_key_decode
    import contra_pkg::*;
#(
    parameter int NUM_KEYS = 6
) (
    input  logic [8*NUM_KEYS-1:0] keycodes,
    input  logic                  w_prev,
    output logic                  left,
    output logic                  right,
    output logic                  jump_edge,
    output logic                  crouch_req,
    output logic                  w_held
);

    logic [NUM_KEYS-1:0] hit_a;
    logic [NUM_KEYS-1:0] hit_d;
    logic [NUM_KEYS-1:0] hit_w;
    logic [NUM_KEYS-1:0] hit_s;

    // Empty lanes (8'd0) never match any of the key codes, so they drop out naturally.
    genvar i;
    generate
        for (i = 0; i < NUM_KEYS; i++) begin : g_lane
            assign hit_a[i] = (keycodes[8*i +: 8] == KEY_A);
            assign hit_d[i] = (keycodes[8*i +: 8] == KEY_D);
            assign hit_w[i] = (keycodes[8*i +: 8] == KEY_W);
            assign hit_s[i] = (keycodes[8*i +: 8] == KEY_S);
        end
    endgenerate

    assign left       = |hit_a;
    assign right      = |hit_d;
    assign w_held     = |hit_w;
    assign crouch_req = |hit_s;
    assign jump_edge  = w_held && !w_prev;

endmodule

// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: per-frame player kinematics - clamped horizontal motion plus a jump/gravity FSM.
// Define DOUBLE_JUMP_EN to accept one extra jump edge while airborne.
//
// state  | meaning
// GROUND | standing at Y_FLOOR; a W edge launches a jump
// RISE   | moving up, gravity shrinking the upward speed
// FALL   | moving down, speed capped at MAX_FALL until the floor
module player_motion_ctrl
    import contra_pkg::*;
#(
    parameter int COORD_W  = 10,
    parameter int NUM_KEYS = 6,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 639,
    parameter int Y_MIN    = 0,
    parameter int Y_FLOOR  = 400,
    parameter int X_START  = 320,
    parameter int SIZE     = 4,
    parameter int X_STEP   = 2,
    parameter int JUMP_V   = 12,
    parameter int GRAVITY  = 1,
    parameter int MAX_FALL = 8
) (
    input  logic                  frame_clk,
    input  logic                  Reset_n,
    input  logic [8*NUM_KEYS-1:0] keycodes,
    input  logic [1:0]            gameState,
    output logic [COORD_W-1:0]    PlayerX,
    output logic [COORD_W-1:0]    PlayerY,
    output logic [COORD_W-1:0]    PlayerS,
    output logic                  facing,
    output logic                  airborne,
    output logic                  crouch
);

    localparam int SW = COORD_W + 2;

    localparam logic signed [SW-1:0] X_LO  = SW'(X_MIN + SIZE);
    localparam logic signed [SW-1:0] X_HI  = SW'(X_MAX - SIZE);
    localparam logic signed [SW-1:0] Y_TOP = SW'(Y_MIN + SIZE);
    localparam logic signed [SW-1:0] Y_BOT = SW'(Y_FLOOR);

    localparam logic signed [7:0] STEP_V   = 8'(X_STEP);
    localparam logic signed [7:0] JUMP_VV  = 8'(JUMP_V);
    localparam logic signed [7:0] GRAV_V   = 8'(GRAVITY);
    localparam logic signed [7:0] FALL_MAX = 8'(MAX_FALL);

    localparam logic [COORD_W-1:0] X_RST  = COORD_W'(X_START);
    localparam logic [COORD_W-1:0] Y_RST  = COORD_W'(Y_FLOOR);
    localparam logic [COORD_W-1:0] SIZE_C = COORD_W'(SIZE);

    function automatic logic signed [SW-1:0] wide_coord(input logic [COORD_W-1:0] c);
        return $signed({2'b00, c});
    endfunction

    function automatic logic signed [SW-1:0] wide_vel(input logic signed [7:0] v);
        return $signed({{(SW-8){v[7]}}, v});
    endfunction

    logic [COORD_W-1:0] x_q, y_q;
    logic signed [7:0]  vy_q;
    vstate_t            vstate;
    logic               facing_q, crouch_q, airborne_q, w_prev_q;

    logic left, right, jump_edge, crouch_req, w_held;

    logic signed [7:0]    vx, vy_eff, vy_inc, vy_nx;
    logic signed [SW-1:0] x_sum, y_sum;
    logic [COORD_W-1:0]   x_nx, y_nx;
    vstate_t              st_nx;
    logic                 facing_nx, crouch_now, jump_ok;

`ifdef DOUBLE_JUMP_EN
    logic dj_used_q, dj_take, dj_nx;
`endif

    player_key_decode #(
        .NUM_KEYS (NUM_KEYS)
    ) u_key_decode (
        .keycodes   (keycodes),
        .w_prev     (w_prev_q),
        .left       (left),
        .right      (right),
        .jump_edge  (jump_edge),
        .crouch_req (crouch_req),
        .w_held     (w_held)
    );

    always_comb begin
        crouch_now = (vstate == GROUND) && crouch_req;
        vx = '0;
        if (!crouch_now) begin
            if (left && !right)
                vx = -STEP_V;
            else if (right && !left)
                vx = STEP_V;
        end

        x_sum = wide_coord(x_q) + wide_vel(vx);
        if (x_sum < X_LO)
            x_nx = X_LO[COORD_W-1:0];
        else if (x_sum > X_HI)
            x_nx = X_HI[COORD_W-1:0];
        else
            x_nx = x_sum[COORD_W-1:0];

        facing_nx = (vx != 8'sd0) ? !vx[7] : facing_q;
    end

    // A jump edge reuses the RISE update with the launch speed, so Y moves on the same edge.
    always_comb begin
        jump_ok = jump_edge && (vstate == GROUND);
`ifdef DOUBLE_JUMP_EN
        dj_take = jump_edge && (vstate != GROUND) && !dj_used_q;
        jump_ok = jump_ok || dj_take;
`endif
        vy_eff = jump_ok ? -JUMP_VV : vy_q;
        y_sum  = wide_coord(y_q) + wide_vel(vy_eff);
        vy_inc = vy_eff + GRAV_V;

        y_nx  = y_q;
        vy_nx = vy_q;
        st_nx = vstate;
        if (jump_ok || vstate == RISE) begin
            if (y_sum <= Y_TOP) begin
                y_nx  = Y_TOP[COORD_W-1:0];
                vy_nx = '0;
                st_nx = FALL;
            end else begin
                y_nx  = y_sum[COORD_W-1:0];
                vy_nx = vy_inc;
                st_nx = vy_inc[7] ? RISE : FALL;
            end
        end else if (vstate == FALL) begin
            if (y_sum >= Y_BOT) begin
                y_nx  = Y_BOT[COORD_W-1:0];
                vy_nx = '0;
                st_nx = GROUND;
            end else begin
                y_nx  = y_sum[COORD_W-1:0];
                vy_nx = (vy_inc > FALL_MAX) ? FALL_MAX : vy_inc;
            end
        end

`ifdef DOUBLE_JUMP_EN
        dj_nx = dj_used_q;
        if (dj_take)
            dj_nx = 1'b1;
        else if (st_nx == GROUND)
            dj_nx = 1'b0;
`endif
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset_n) begin
            x_q        <= X_RST;
            y_q        <= Y_RST;
            vy_q       <= '0;
            vstate     <= GROUND;
            facing_q   <= 1'b1;
            crouch_q   <= 1'b0;
            airborne_q <= 1'b0;
            w_prev_q   <= 1'b0;
`ifdef DOUBLE_JUMP_EN
            dj_used_q  <= 1'b0;
`endif
        end else if (gameState == GS_PLAY) begin
            x_q        <= x_nx;
            y_q        <= y_nx;
            vy_q       <= vy_nx;
            vstate     <= st_nx;
            facing_q   <= facing_nx;
            crouch_q   <= (st_nx == GROUND) && crouch_req;
            airborne_q <= (st_nx != GROUND);
            w_prev_q   <= w_held;
`ifdef DOUBLE_JUMP_EN
            dj_used_q  <= dj_nx;
`endif
        end
    end

    assign PlayerX  = x_q;
    assign PlayerY  = y_q;
    assign PlayerS  = SIZE_C;
    assign facing   = facing_q;
    assign airborne = airborne_q;
    assign crouch   = crouch_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// tb_player_motion_ctrl: directed self-checking bench for player_motion_ctrl.
module tb_player_motion_ctrl;

    logic        frame_clk = 1'b0;
    logic        Reset_n;
    logic [47:0] keycodes;
    logic [1:0]  gameState;
    logic [9:0]  PlayerX, PlayerY, PlayerS;
    logic        facing, airborne, crouch;

    int n_checks = 0;
    int n_fail   = 0;

    // Hand-computed Y after each frame of a single jump launched from Y=400.
    int traj [1:27] = '{388, 377, 367, 358, 350, 343, 337, 332, 328, 325, 323, 322,
                        322, 323, 325, 328, 332, 337, 343, 350, 358, 366, 374, 382,
                        390, 398, 400};

    player_motion_ctrl dut (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .keycodes  (keycodes),
        .gameState (gameState),
        .PlayerX   (PlayerX),
        .PlayerY   (PlayerY),
        .PlayerS   (PlayerS),
        .facing    (facing),
        .airborne  (airborne),
        .crouch    (crouch)
    );

    always #5 frame_clk = ~frame_clk;

    function automatic logic [47:0] lane(input int idx, input logic [7:0] code);
        logic [47:0] v;
        v = '0;
        v[8*idx +: 8] = code;
        return v;
    endfunction

    task automatic frame();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; gameState = 2'd0; keycodes = '0;
        frame(); frame();
        n_checks++;
        if (PlayerX !== 10'd320 || PlayerY !== 10'd400 || airborne !== 1'b0 || facing !== 1'b1 || crouch !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: X=%0d Y=%0d air=%b face=%b crouch=%b, want 320 400 0 1 0", PlayerX, PlayerY, airborne, facing, crouch);
        end
        n_checks++;
        if (PlayerS !== 10'd4) begin
            n_fail++;
            $display("FAIL size: got %0d want 4", PlayerS);
        end
        Reset_n = 1'b1; gameState = 2'd1;
        for (int i = 0; i < 5; i++) frame();
        n_checks++;
        if (PlayerX !== 10'd320 || PlayerY !== 10'd400 || airborne !== 1'b0 || facing !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_play: X=%0d Y=%0d air=%b face=%b, want 320 400 0 1", PlayerX, PlayerY, airborne, facing);
        end
    endtask

    task automatic test_both_keys();
        keycodes = lane(0, 8'd4) | lane(1, 8'd7);
        for (int i = 1; i <= 10; i++) begin
            frame();
            n_checks++;
            if (PlayerX !== 10'd320 || facing !== 1'b1) begin
                n_fail++;
                $display("FAIL both_keys f%0d: X=%0d face=%b, want 320 1", i, PlayerX, facing);
            end
        end
    endtask

    task automatic test_left();
        int exp_x;
        keycodes = lane(3, 8'd4);
        for (int i = 1; i <= 165; i++) begin
            frame();
            exp_x = (320 - 2*i < 4) ? 4 : 320 - 2*i;
            n_checks++;
            if (int'(PlayerX) != exp_x) begin
                n_fail++;
                $display("FAIL left_step f%0d: X=%0d want %0d", i, PlayerX, exp_x);
            end
        end
        n_checks++;
        if (facing !== 1'b0) begin
            n_fail++;
            $display("FAIL left_facing: got %b want 0", facing);
        end
    endtask

    task automatic test_right_clamp();
        int exp_x;
        keycodes = lane(5, 8'd7);
        for (int i = 1; i <= 320; i++) begin
            frame();
            exp_x = (4 + 2*i > 635) ? 635 : 4 + 2*i;
            n_checks++;
            if (int'(PlayerX) != exp_x) begin
                n_fail++;
                $display("FAIL right_step f%0d: X=%0d want %0d", i, PlayerX, exp_x);
            end
        end
        n_checks++;
        if (facing !== 1'b1) begin
            n_fail++;
            $display("FAIL right_facing: got %b want 1", facing);
        end
    endtask

    task automatic test_crouch();
        keycodes = lane(0, 8'd22) | lane(1, 8'd4);
        for (int i = 1; i <= 4; i++) begin
            frame();
            n_checks++;
            if (PlayerX !== 10'd635 || crouch !== 1'b1 || facing !== 1'b1) begin
                n_fail++;
                $display("FAIL crouch f%0d: X=%0d crouch=%b face=%b, want 635 1 1", i, PlayerX, crouch, facing);
            end
        end
        keycodes = '0;
        frame();
        n_checks++;
        if (crouch !== 1'b0) begin
            n_fail++;
            $display("FAIL crouch_release: got %b want 0", crouch);
        end
    endtask

    task automatic test_jump();
        for (int i = 1; i <= 27; i++) begin
            keycodes = (i == 1) ? lane(2, 8'd26) : '0;
            frame();
            n_checks++;
            if (int'(PlayerY) != traj[i] || airborne !== (i < 27) || PlayerX !== 10'd635) begin
                n_fail++;
                $display("FAIL jump f%0d: Y=%0d air=%b X=%0d, want %0d %b 635", i, PlayerY, airborne, PlayerX, traj[i], (i < 27));
            end
        end
    endtask

    task automatic test_w_held();
        keycodes = lane(4, 8'd26);
        for (int i = 1; i <= 32; i++) begin
            frame();
            n_checks++;
            if (int'(PlayerY) != ((i <= 27) ? traj[i] : 400) || airborne !== (i < 27)) begin
                n_fail++;
                $display("FAIL w_held f%0d: Y=%0d air=%b, want %0d %b", i, PlayerY, airborne, (i <= 27) ? traj[i] : 400, (i < 27));
            end
        end
        keycodes = '0;
        frame();
        keycodes = lane(4, 8'd26);
        frame();
        n_checks++;
        if (PlayerY !== 10'd388 || airborne !== 1'b1) begin
            n_fail++;
            $display("FAIL w_rejump: Y=%0d air=%b, want 388 1", PlayerY, airborne);
        end
        keycodes = '0;
        for (int i = 2; i <= 27; i++) frame();
        n_checks++;
        if (PlayerY !== 10'd400 || airborne !== 1'b0) begin
            n_fail++;
            $display("FAIL w_reland: Y=%0d air=%b, want 400 0", PlayerY, airborne);
        end
    endtask

    task automatic test_pause();
        for (int i = 1; i <= 5; i++) begin
            keycodes = (i == 1) ? lane(0, 8'd26) : '0;
            frame();
        end
        gameState = 2'd0;
        keycodes  = lane(0, 8'd26) | lane(1, 8'd4);
        for (int i = 1; i <= 20; i++) begin
            frame();
            n_checks++;
            if (PlayerY !== 10'd350 || PlayerX !== 10'd635 || airborne !== 1'b1) begin
                n_fail++;
                $display("FAIL pause f%0d: Y=%0d X=%0d air=%b, want 350 635 1", i, PlayerY, PlayerX, airborne);
            end
        end
        gameState = 2'd1;
        keycodes  = '0;
        for (int i = 6; i <= 27; i++) begin
            frame();
            n_checks++;
            if (int'(PlayerY) != traj[i]) begin
                n_fail++;
                $display("FAIL resume f%0d: Y=%0d want %0d", i, PlayerY, traj[i]);
            end
        end
    endtask

    task automatic test_reset_midjump();
        keycodes = lane(0, 8'd26) | lane(1, 8'd4);
        frame();
        keycodes = lane(1, 8'd4);
        for (int i = 2; i <= 5; i++) frame();
        n_checks++;
        if (PlayerY !== 10'd350 || PlayerX !== 10'd625 || facing !== 1'b0) begin
            n_fail++;
            $display("FAIL prereset: Y=%0d X=%0d face=%b, want 350 625 0", PlayerY, PlayerX, facing);
        end
        Reset_n = 1'b0;
        frame();
        n_checks++;
        if (PlayerX !== 10'd320 || PlayerY !== 10'd400 || airborne !== 1'b0 || facing !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_midjump: X=%0d Y=%0d air=%b face=%b, want 320 400 0 1", PlayerX, PlayerY, airborne, facing);
        end
        Reset_n = 1'b1; keycodes = '0;
        frame(); frame();
        n_checks++;
        if (PlayerY !== 10'd400 || airborne !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_ground: Y=%0d air=%b, want 400 0", PlayerY, airborne);
        end
        keycodes = lane(2, 8'd4);
        for (int i = 0; i < 3; i++) frame();
        gameState = 2'd0; Reset_n = 1'b0;
        frame();
        n_checks++;
        if (PlayerX !== 10'd320 || facing !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_paused: X=%0d face=%b, want 320 1", PlayerX, facing);
        end
        Reset_n = 1'b1; gameState = 2'd1; keycodes = '0;
        frame();
    endtask

    task automatic test_air_jump();
        for (int i = 1; i <= 12; i++) begin
            keycodes = (i == 1) ? lane(5, 8'd26) : '0;
            frame();
        end
        keycodes = lane(5, 8'd26);
        frame();
`ifdef DOUBLE_JUMP_EN
        n_checks++;
        if (PlayerY !== 10'd310 || airborne !== 1'b1) begin
            n_fail++;
            $display("FAIL double_jump: Y=%0d air=%b, want 310 1", PlayerY, airborne);
        end
        keycodes = '0;
        frame();
        keycodes = lane(5, 8'd26);
        frame();
        n_checks++;
        if (PlayerY !== 10'd289) begin
            n_fail++;
            $display("FAIL third_jump_ignored: Y=%0d want 289", PlayerY);
        end
`else
        n_checks++;
        if (PlayerY !== 10'd322 || airborne !== 1'b1) begin
            n_fail++;
            $display("FAIL air_jump_ignored: Y=%0d air=%b, want 322 1", PlayerY, airborne);
        end
        keycodes = '0;
        frame();
        keycodes = lane(5, 8'd26);
        frame();
        n_checks++;
        if (PlayerY !== 10'd325) begin
            n_fail++;
            $display("FAIL air_jump_ignored2: Y=%0d want 325", PlayerY);
        end
`endif
        keycodes = '0;
        for (int k = 0; k < 80 && airborne !== 1'b0; k++) frame();
        n_checks++;
        if (airborne !== 1'b0 || PlayerY !== 10'd400) begin
            n_fail++;
            $display("FAIL air_jump_land: air=%b Y=%0d, want 0 400 within 80 frames", airborne, PlayerY);
        end
    endtask

    initial begin
        Reset_n = 1'b0; gameState = 2'd0; keycodes = '0;
        test_reset();
        test_both_keys();
        test_left();
        test_right_clamp();
        test_crouch();
        test_jump();
        test_w_held();
        test_pause();
        test_reset_midjump();
        test_air_jump();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
